load_store_unit: RTL and testbench

//  Initiator for the byte-addressed, big-endian 32-bit data memory (dataMem port).

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory signals of the load/store unit
// slave: the load/store unit itself; master: the core datapath plus data memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian byte/half/word load/store initiator with read-modify-write stores
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of forcing alignment.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input logic              CLK,
  input logic              RST,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        req_err;
  logic [1:0]  req_off;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      m[15:0] = d;
    end else begin
      m[31:16] = d;
    end
    return m;
  endfunction

  // Lane offset is forced to the natural alignment of the size; the optional check turns misalignment into an error.
  always_comb begin
    req_err = (bus.req_size == 2'b11) || (bus.req_addr >= MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
    req_err = req_err || ((bus.req_size == 2'b01) && bus.req_addr[0])
                      || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    req_err = req_err || 1'b0;
`endif
    case (bus.req_size)
      2'b00:   req_off = bus.req_addr[1:0];
      2'b01:   req_off = {bus.req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          size_d     = bus.req_size;
          uns_d      = bus.req_unsigned;
          off_d      = req_off;
          wdata_d    = bus.req_wdata[15:0];
          mem_addr_d = {bus.req_addr[31:2], 2'b00};
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_size == 2'b10)) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_wdata_d = lane_merge(bus.mem_rdata, size_q, off_q, wdata_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_extract(bus.mem_rdata, size_q, uns_q, off_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a big-endian byte memory model
module tb_load_store_unit;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  logic load_mem;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   both_cnt = 0;
  int   resp_cnt = 0;
  logic [31:0] last_raddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [7:0]  img [0:511];
  logic [7:0]  mem [0:511];
  vec_t        vecs[$];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(512)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    int a;
    a = int'(bus.mem_addr[8:0]);
    if (bus.mem_addr < 32'd509)
      bus.mem_rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    else
      bus.mem_rdata = 32'h0;
  end

  always @(posedge CLK) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= img[i];
    end else if (bus.mem_write && (bus.mem_addr < 32'd509)) begin
      mem[int'(bus.mem_addr[8:0])]     <= bus.mem_wdata[31:24];
      mem[int'(bus.mem_addr[8:0]) + 1] <= bus.mem_wdata[23:16];
      mem[int'(bus.mem_addr[8:0]) + 2] <= bus.mem_wdata[15:8];
      mem[int'(bus.mem_addr[8:0]) + 3] <= bus.mem_wdata[7:0];
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.mem_read) begin
        rd_cnt = rd_cnt + 1;
        last_raddr = bus.mem_addr;
      end
      if (bus.mem_write) begin
        wr_cnt = wr_cnt + 1;
        last_wdata = bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_write) both_cnt = both_cnt + 1;
      if (bus.resp_valid) resp_cnt = resp_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                              input int rd, input int wr, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int  n;
    int  rd0;
    int  wr0;
    bit  got;
    @(negedge CLK);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_size     = SZ_X;
    bus.req_addr     = 32'hFFFF_FFFF;
    bus.req_wdata    = 32'h5A5A_5A5A;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge CLK);
      n++;
      if (bus.resp_valid) got = 1'b1;
    end
    chk({nm, "_resp_seen"}, {31'h0, got}, 32'h1);
    chk({nm, "_latency"}, n, v.exp_lat);
    chk({nm, "_rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({nm, "_err"}, {31'h0, bus.resp_err}, {31'h0, v.exp_err});
    @(negedge CLK);
    chk({nm, "_pulse_end"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({nm, "_reads"}, rd_cnt - rd0, v.exp_rd);
    chk({nm, "_writes"}, wr_cnt - wr0, v.exp_wr);
    if (v.exp_rd > 0) chk({nm, "_raddr"}, last_raddr, {v.addr[31:2], 2'b00});
    if (v.exp_wr > 0) chk({nm, "_wdata"}, last_wdata, v.exp_wdata);
  endtask

  initial begin
    int wr0;
    int rsp0;
    for (int i = 0; i < 512; i++) img[i] = 8'h00;
    img[16] = 8'h11; img[17] = 8'h22; img[18] = 8'h33; img[19] = 8'h44;
    img[20] = 8'h55; img[21] = 8'h66; img[22] = 8'h77; img[23] = 8'h88;
    img[508] = 8'h00; img[509] = 8'h00; img[510] = 8'h7F; img[511] = 8'h01;

    vecs.push_back(mk(0, SZ_W, 0, 32'h10,  32'h0,        32'h1122_3344, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_B, 0, 32'h12,  32'h0000_00A5, 32'h0,        0, 3, 1, 1, 32'h1122_A544));
    vecs.push_back(mk(0, SZ_B, 0, 32'h12,  32'h0,        32'hFFFF_FFA5, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_B, 1, 32'h12,  32'h0,        32'h0000_00A5, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_H, 0, 32'h12,  32'h0,        32'hFFFF_A544, 0, 2, 1, 0, 32'h0));
`ifdef LSU_ALIGN_CHECK_EN
    vecs.push_back(mk(0, SZ_W, 0, 32'h11,  32'h0,        32'h0,         1, 1, 0, 0, 32'h0));
`else
    vecs.push_back(mk(0, SZ_W, 0, 32'h11,  32'h0,        32'h1122_A544, 0, 2, 1, 0, 32'h0));
`endif
    vecs.push_back(mk(1, SZ_W, 0, 32'h200, 32'h1234_5678, 32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, SZ_H, 0, 32'h16,  32'hFFFF_BEEF, 32'h0,        0, 3, 1, 1, 32'h5566_BEEF));
    vecs.push_back(mk(0, SZ_H, 1, 32'h16,  32'h0,        32'h0000_BEEF, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_H, 0, 32'h14,  32'h0,        32'h0000_5566, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_W, 0, 32'h18,  32'hDEAD_BEEF, 32'h0,        0, 2, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, SZ_B, 0, 32'h19,  32'h0,        32'hFFFF_FFAD, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_B, 1, 32'h1B,  32'h0,        32'h0000_00EF, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_X, 0, 32'h10,  32'h0,        32'h0,         1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, SZ_H, 0, 32'h1FE, 32'h0,        32'h0000_7F01, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_B, 0, 32'h1FF, 32'h0,        32'h0000_0001, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_B, 0, 32'h200, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, SZ_B, 0, 32'h10,  32'hFFFF_FF80, 32'h0,        0, 3, 1, 1, 32'h8022_A544));
    vecs.push_back(mk(0, SZ_W, 0, 32'h10,  32'h0,        32'h8022_A544, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_B, 0, 32'h10,  32'h0,        32'hFFFF_FF80, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_W, 0, 32'h20,  32'h0102_0304, 32'h0,        0, 2, 0, 1, 32'h0102_0304));
`ifdef LSU_ALIGN_CHECK_EN
    vecs.push_back(mk(0, SZ_H, 0, 32'h21,  32'h0,        32'h0,         1, 1, 0, 0, 32'h0));
`else
    vecs.push_back(mk(0, SZ_H, 0, 32'h21,  32'h0,        32'h0000_0102, 0, 2, 1, 0, 32'h0));
`endif
    vecs.push_back(mk(0, SZ_B, 1, 32'h23,  32'h0,        32'h0000_0004, 0, 2, 1, 0, 32'h0));

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    RST = 1'b1;
    load_mem = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_mem_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    RST = 1'b0;
    load_mem = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset lands while a sub-word store is in its read cycle: the write must never happen.
    wr0 = wr_cnt;
    rsp0 = resp_cnt;
    @(negedge CLK);
    bus.req_we = 1'b1; bus.req_size = SZ_B; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h14; bus.req_wdata = 32'h0000_0099;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("rstmid_in_rd", {31'h0, bus.mem_read}, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmid_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rstmid_resp", {31'h0, bus.resp_valid}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge CLK);
    chk("rstmid_no_write", wr_cnt - wr0, 32'h0);
    chk("rstmid_no_resp", resp_cnt - rsp0, 32'h0);
    chk("rstmid_mem_byte", {24'h0, mem[20]}, 32'h55);
    run_vec(mk(0, SZ_B, 1, 32'h14, 32'h0, 32'h0000_0055, 0, 2, 1, 0, 32'h0), "after_rst");

    chk("never_both_strobes", both_cnt, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
